sha256_wsched_rev: RTL and testbench

//  Reverse SHA-256 message-schedule unit: the inverse of the forward expansion
//  W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].

---
 rtl/sha256_wsched_rev.sv | 132 +++++++++++++
 tb/tb_sha256_wsched_rev.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_wsched_rev.sv
// Reverse SHA-256 message-schedule unit.
// Loads the last sixteen schedule words W48..W63 and then regenerates W47, W46, ... one word per
// accepted output beat. Each step inverts the forward expansion:
//   W[t-16] = W[t] - s1(W[t-2]) - W[t-7] - s0(W[t-15])
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   in_valid_i   load word valid
//   in_ready_o   load word accepted when in_valid_i & in_ready_o
//   in_word_i    load word, W48 first ... W63 last
//   out_valid_o  regenerated word valid
//   out_ready_i  consumer ready
//   out_word_o   regenerated word, W47 first, descending
//   out_last_o   high with the final word
//   done_o       one-cycle pulse on the cycle after the final beat
module sha256_wsched_rev #(
  parameter int unsigned NUM_OUT = 48
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_word_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic        out_last_o,
  output logic        done_o
);

  localparam logic [5:0] NumOutW = 6'(NUM_OUT);

  typedef enum logic [1:0] {StLoad, StPrime, StOut} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] r [16];          // r[k] holds W[base+k]
  logic [4:0]  ld_cnt;
  logic [5:0]  out_cnt;
  logic [31:0] prev_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // W[base-1], the word that precedes the current window
  assign prev_word = r[15] - sig1(r[13]) - r[8] - sig0(r[0]);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= StLoad;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      StLoad: begin
        if (in_valid_i && (ld_cnt == 5'd15)) state_next = StPrime;
      end
      StPrime: state_next = StOut;
      StOut: begin
        if (out_ready_i && (out_cnt == NumOutW)) state_next = StLoad;
      end
      default: state_next = StLoad;
    endcase
  end

  // Combinational outputs
  always_comb begin
    in_ready_o = (state == StLoad);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 16; k++) r[k] <= '0;
      ld_cnt      <= '0;
      out_cnt     <= '0;
      out_valid_o <= 1'b0;
      out_word_o  <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        StLoad: begin
          if (in_valid_i) begin
            for (int k = 0; k < 15; k++) r[k] <= r[k+1];
            r[15]  <= in_word_i;
            ld_cnt <= ld_cnt + 5'd1;
          end
        end
        StPrime: begin
          out_word_o <= prev_word;
          r[0]       <= prev_word;
          for (int k = 1; k < 16; k++) r[k] <= r[k-1];
          out_cnt     <= 6'd1;
          out_valid_o <= 1'b1;
          out_last_o  <= (NumOutW == 6'd1);
        end
        StOut: begin
          if (out_ready_i) begin
            if (out_cnt < NumOutW) begin
              out_word_o <= prev_word;
              r[0]       <= prev_word;
              for (int k = 1; k < 16; k++) r[k] <= r[k-1];
              out_cnt    <= out_cnt + 6'd1;
              out_last_o <= ((out_cnt + 6'd1) == NumOutW);
            end else begin
              // final word consumed; out_word_o keeps its value
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
              done_o      <= 1'b1;
              ld_cnt      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_wsched_rev.sv
// Self-checking bench for sha256_wsched_rev. Two instances: NUM_OUT=48 and NUM_OUT=16, selected by
// sel16. Inputs are driven and outputs sampled on the falling clock edge.
module tb_sha256_wsched_rev;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        out_ready = 1'b0;
  logic        sel16 = 1'b0;

  logic        iv48, ir48, ov48, ol48, dn48;
  logic        iv16, ir16, ov16, ol16, dn16;
  logic [31:0] ow48, ow16;

  logic        o_ready_in, o_valid, o_last, o_done;
  logic [31:0] o_word;

  int checks = 0;
  int failures = 0;

  logic [31:0] wfull   [64];
  logic [31:0] ld_buf  [16];
  logic [31:0] exp_buf [48];
  logic [31:0] got_buf [48];

  always #5 clk = ~clk;

  assign iv48 = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;

  assign o_ready_in = sel16 ? ir16 : ir48;
  assign o_valid    = sel16 ? ov16 : ov48;
  assign o_word     = sel16 ? ow16 : ow48;
  assign o_last     = sel16 ? ol16 : ol48;
  assign o_done     = sel16 ? dn16 : dn48;

  sha256_wsched_rev #(.NUM_OUT(48)) dut48 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv48), .in_ready_o(ir48), .in_word_i(in_word),
    .out_valid_o(ov48), .out_ready_i(out_ready), .out_word_o(ow48), .out_last_o(ol48),
    .done_o(dn48)
  );

  sha256_wsched_rev #(.NUM_OUT(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(ir16), .in_word_i(in_word),
    .out_valid_o(ov16), .out_ready_i(out_ready), .out_word_o(ow16), .out_last_o(ol16),
    .done_o(dn16)
  );

  // Forward schedule model
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic setup_abc();
    for (int t = 0; t < 16; t++) wfull[t] = '0;
    wfull[0]  = 32'h6162_6380;
    wfull[15] = 32'h0000_0018;
    for (int t = 16; t < 64; t++)
      wfull[t] = ss1(wfull[t-2]) + wfull[t-7] + ss0(wfull[t-15]) + wfull[t-16];
    for (int i = 0; i < 16; i++) ld_buf[i] = wfull[48+i];
    for (int i = 0; i < 48; i++) exp_buf[i] = wfull[47-i];
  endtask

  task automatic setup_zero();
    for (int i = 0; i < 16; i++) ld_buf[i] = '0;
    for (int i = 0; i < 48; i++) exp_buf[i] = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Sixteen back-to-back load beats; optionally leaves in_valid high with junk afterwards.
  task automatic load16(input bit hold_junk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (o_ready_in !== 1'b1) begin
        failures++;
        $display("FAIL load_ready beat=%0d got=%b want=1", i, o_ready_in);
      end
      in_valid = 1'b1;
      in_word  = ld_buf[i];
    end
    @(negedge clk);
    if (hold_junk) in_word = 32'hDEAD_BEEF;
    else in_valid = 1'b0;
    checks++;
    if (o_ready_in !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL prime_state in_ready=%b out_valid=%b want 0/0", o_ready_in, o_valid);
    end
  endtask

  // Consumes n words, comparing against exp_buf; optionally checks the done pulse.
  task automatic collect(input int n, input int nout, input int duty, input bit want_done,
                         output int first_cyc, output int last_cyc);
    int idx;
    int cyc;
    bit stalled;
    bit rdy;
    logic [31:0] held;
    idx = 0; cyc = 0; stalled = 0; held = '0; first_cyc = -1; last_cyc = -1;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if (o_word !== held || o_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_stable idx=%0d got=%h/%b want=%h/1", idx, o_word, o_valid, held);
        end
      end
      stalled = 0;
      rdy = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      out_ready = rdy;
      if (o_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rdy) begin
          got_buf[idx] = o_word;
          checks++;
          if (o_word !== exp_buf[idx]) begin
            failures++;
            $display("FAIL word idx=%0d got=%h want=%h", idx, o_word, exp_buf[idx]);
          end
          checks++;
          if (o_last !== (idx == nout - 1)) begin
            failures++;
            $display("FAIL last_flag idx=%0d got=%b want=%b", idx, o_last, (idx == nout - 1));
          end
          last_cyc = cyc;
          idx++;
        end else begin
          stalled = 1;
          held = o_word;
        end
      end
    end
    if (idx < n) begin
      checks++; failures++;
      $display("FAIL stream_timeout got=%0d words want=%0d", idx, n);
    end
    @(negedge clk);
    if (want_done) begin
      checks++;
      if (o_done !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0 || o_ready_in !== 1'b1) begin
        failures++;
        $display("FAIL done_cycle done=%b valid=%b last=%b in_ready=%b want 1/0/0/1",
                 o_done, o_valid, o_last, o_ready_in);
      end
      checks++;
      if (o_word !== exp_buf[n-1]) begin
        failures++;
        $display("FAIL word_hold got=%h want=%h", o_word, exp_buf[n-1]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (want_done) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin
        failures++;
        $display("FAIL done_width got=%b want=0", o_done);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_ready_in !== 1'b1 || o_valid !== 1'b0 || o_word !== 32'h0 || o_last !== 1'b0 ||
        o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values ready=%b valid=%b word=%h last=%b done=%b want 1/0/0/0/0",
               o_ready_in, o_valid, o_word, o_last, o_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_abc();
    int f, l;
    setup_abc();
    load16(1'b0);
    collect(48, 48, 100, 1'b1, f, l);
    checks++;
    if (f !== 1) begin
      failures++;
      $display("FAIL abc_latency got=%0d want=1", f);
    end
    checks++;
    if (got_buf[32] !== 32'h0000_0018) begin
      failures++;
      $display("FAIL abc_w15 got=%h want=00000018", got_buf[32]);
    end
    checks++;
    if (got_buf[47] !== 32'h6162_6380) begin
      failures++;
      $display("FAIL abc_w0 got=%h want=61626380", got_buf[47]);
    end
    checks++;
    if (got_buf[31] !== 32'h6162_6380 || got_buf[30] !== 32'h000f_0000) begin
      failures++;
      $display("FAIL abc_w16_w17 got=%h,%h want=61626380,000f0000", got_buf[31], got_buf[30]);
    end
  endtask

  task automatic test_zero();
    int f, l;
    setup_zero();
    load16(1'b0);
    collect(48, 48, 100, 1'b1, f, l);
    checks++;
    if (l - f !== 47) begin
      failures++;
      $display("FAIL zero_back_to_back span got=%0d want=47", l - f);
    end
  endtask

  task automatic test_backpressure();
    int f, l;
    setup_abc();
    load16(1'b0);
    collect(48, 48, 30, 1'b1, f, l);
  endtask

  task automatic test_junk_valid();
    int f, l;
    setup_abc();
    load16(1'b1);
    collect(48, 48, 100, 1'b1, f, l);
    // second load right after done proves no junk word was taken
    load16(1'b0);
    collect(48, 48, 100, 1'b1, f, l);
  endtask

  task automatic test_reset_midstream();
    int f, l;
    setup_abc();
    load16(1'b0);
    collect(20, 48, 100, 1'b0, f, l);
    apply_reset();
    checks++;
    if (o_word !== 32'h0 || o_valid !== 1'b0 || o_ready_in !== 1'b1) begin
      failures++;
      $display("FAIL midstream_reset word=%h valid=%b ready=%b want 0/0/1",
               o_word, o_valid, o_ready_in);
    end
    setup_zero();
    load16(1'b0);
    collect(48, 48, 100, 1'b1, f, l);
  endtask

  task automatic test_num_out16();
    int f, l;
    sel16 = 1'b1;
    setup_abc();
    load16(1'b0);
    collect(16, 16, 100, 1'b1, f, l);
    checks++;
    if (got_buf[15] !== wfull[32]) begin
      failures++;
      $display("FAIL n16_last_word got=%h want=%h", got_buf[15], wfull[32]);
    end
    sel16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_junk_valid();
    test_reset_midstream();
    test_num_out16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
